fork_n_service: RTL and testbench
=================================

Name: fork_n_service

Overview:
- N-way, packet-granular splitter for the back-end packet path; a parametrised successor to the fixed two-way fork.
- Steers each whole packet, SOP to EOP, to one of N_OUT output channels, or drops it.
- The destination is taken from a selector field in the packet's SOP flit.
- Keeps per-output packet counters plus drop and protocol-error counters.
- Sits between the string-matcher packet output and the downstream consumers (no-check path, full-check path, further engines).

Parameters:
- DATA_BITS, 512, flit data width.
- EMPTY_BITS, 6, width of the empty-byte count.
- N_OUT, 4, number of output channels, 2..16.
- SEL_LSB, 0, bit position of the selector field in the SOP flit's in_data.
- SEL_BITS, 4, selector field width; must satisfy 2^SEL_BITS >= N_OUT.

Ports:
- Clk  in  1  clock.
- Rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_BITS  input flit.
- in_valid  in  1  input flit valid.
- in_ready  out  1  input accept.
- in_sop  in  1  start of packet.
- in_eop  in  1  end of packet.
- in_empty  in  EMPTY_BITS  empty bytes on the EOP flit.
- out_data  out  N_OUT*DATA_BITS  per-channel data; all lanes carry the same registered flit.
- out_valid  out  N_OUT  per-channel valid.
- out_ready  in  N_OUT  per-channel ready.
- out_sop  out  N_OUT  per-channel SOP.
- out_eop  out  N_OUT  per-channel EOP.
- out_empty  out  N_OUT*EMPTY_BITS  per-channel empty.
- stats_clr  in  1  synchronous clear of all counters.
- stats_pkt  out  N_OUT*32  packets completed per channel; lane i at [32i+:32].
- stats_drop  out  32  packets dropped because the selector was out of range.
- stats_err  out  32  protocol-violation flits.

Behaviour:
- Handshakes:
  - A transfer occurs when valid and ready are both high in the same cycle.
  - Valid never depends on ready.
  - Once asserted, out_valid and the output payload hold until accepted.
- Output stage:
  - One output register holds {flit, dest}; r_valid flags occupancy.
  - in_ready = !r_valid || out_ready[dest], or 1 when the FSM is in DROP.
  - Latency is one cycle from input accept to out_valid.
  - Full throughput (one flit per cycle) under continuous ready.
- FSM states: IDLE, FWD, DROP.
  - IDLE, accepted flit with SOP: sel = in_data[SEL_LSB+:SEL_BITS].
    - If sel < N_OUT: dest <= sel, flit is loaded, go to FWD.
    - Otherwise: flit is discarded, go to DROP.
    - If the SOP flit also has EOP: stay in IDLE after forwarding, or increment stats_drop when out of range.
  - IDLE, accepted flit without SOP: discard it, stats_err++.
  - FWD: each accepted flit goes to dest. On EOP, return to IDLE.
  - DROP: all flits are accepted and discarded. On EOP, stats_drop++ and return to IDLE.
  - SOP seen while in FWD or DROP: stats_err++. The flit is treated as a continuation; the SOP bit is passed through and the selector is ignored.
- Outputs:
  - out_valid[i] = r_valid && dest==i.
  - out_sop, out_eop and out_empty are gated to the dest lane only.
- Counters:
  - stats_pkt[dest]++ when an output transfer with eop occurs on lane dest.
  - All counters are 32-bit and wrap modulo 2^32.
  - stats_clr has priority over a same-cycle increment.
- Reset (mid-packet reset allowed; the partial packet is abandoned, with no EOP emitted):
  - All out_valid, out_sop and out_eop are 0; r_valid=0; FSM goes to IDLE.
  - All counters are 0; out_data and out_empty are 0.
  - in_ready is 1 on the first cycle after reset release.
- Simultaneous events: output accept plus new input in the same cycle reloads the register; there is no bubble.

Optional Feature:
- Macro: FORK_BROADCAST_EN.
- Defined:
  - sel == all-ones (2^SEL_BITS-1) routes the packet to all N_OUT lanes.
  - out_valid is asserted on every lane, and each flit transfers only when all out_ready are high (all-or-none).
  - in_ready = !r_valid || &out_ready.
  - On EOP, every stats_pkt lane increments.
- Undefined:
  - all-ones is an ordinary out-of-range value; the packet is dropped, or routed normally if all-ones < N_OUT.

Test Plan:
- Route by selector:
  - Stimulus: N_OUT=4, 3-flit packet, sel=2, all out_ready=1.
  - Response: flits appear on lane 2 only, one cycle after input; out_sop on the first, out_eop with empty=5 on the last; stats_pkt[2]=1, other lanes 0.
- Backpressure:
  - Stimulus: out_ready[1]=0 for 4 cycles mid-packet on lane 1.
  - Response: out_data held stable; in_ready=0 while r_valid; no flit lost or duplicated; 8-flit packet arrives intact.
- Out-of-range drop:
  - Stimulus: sel=6 with N_OUT=4, 5-flit packet.
  - Response: in_ready=1 throughout, no out_valid, stats_drop=1; the following sel=0 packet is forwarded normally.
- Protocol errors:
  - Stimulus: a flit without SOP in IDLE, then an SOP flit mid-packet.
  - Response: stats_err=2; the in-flight packet still ends on its original lane.
- Reset and clear:
  - Stimulus: Rst_n low during flit 2 of 4; after release, inject a single-flit SOP+EOP packet, then pulse stats_clr together with an EOP transfer.
  - Response: outputs 0 during reset; single-flit packet delivered; counter reads 0 after the clear.
- Broadcast (FORK_BROADCAST_EN):
  - Stimulus: sel=15, 2-flit packet, with out_ready[3] low for 2 cycles.
  - Response: no lane transfers until all are ready; then all 4 lanes receive it; every stats_pkt lane = 1.

Source files
------------

// File: rtl/fork_n_service.sv
// fork_n_service: N-way packet-granular splitter. Each packet (SOP..EOP)
// is steered whole to the output lane named by the selector field of its
// SOP flit, or dropped when that selector is out of range.
// Ports:
//   Clk, Rst_n            clock, asynchronous active-low reset
//   in_*                  input flit stream (valid/ready, sop/eop/empty)
//   out_*                 N_OUT output lanes sharing one registered flit
//   stats_clr             synchronous clear of all counters
//   stats_pkt/drop/err    per-lane packet, dropped-packet, protocol-error
// Build option: define FORK_BROADCAST_EN so that selector all-ones sends
// the packet to every lane (all-or-none transfer).
module fork_n_service #(
    parameter int DATA_BITS  = 512,
    parameter int EMPTY_BITS = 6,
    parameter int N_OUT      = 4,
    parameter int SEL_LSB    = 0,
    parameter int SEL_BITS   = 4
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sop,
    input  logic                          in_eop,
    input  logic [EMPTY_BITS-1:0]         in_empty,
    output logic [N_OUT*DATA_BITS-1:0]    out_data,
    output logic [N_OUT-1:0]              out_valid,
    input  logic [N_OUT-1:0]              out_ready,
    output logic [N_OUT-1:0]              out_sop,
    output logic [N_OUT-1:0]              out_eop,
    output logic [N_OUT*EMPTY_BITS-1:0]   out_empty,
    input  logic                          stats_clr,
    output logic [N_OUT*32-1:0]           stats_pkt,
    output logic [31:0]                   stats_drop,
    output logic [31:0]                   stats_err
);

    localparam int DW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FWD,
        S_DROP
    } state_t;

    state_t                r_state;
    logic                  r_valid;
    logic                  r_sop;
    logic                  r_eop;
    logic                  r_bcast;
    logic [DATA_BITS-1:0]  r_data;
    logic [EMPTY_BITS-1:0] r_empty;
    logic [DW-1:0]         r_dest;
    logic [31:0]           r_pkt [N_OUT];
    logic [31:0]           r_drop;
    logic [31:0]           r_err;

    logic [SEL_BITS-1:0]   w_sel;
    logic                  w_in_range;
    logic                  w_sel_bc;
    logic                  w_out_acc;
    logic                  w_in_acc;
    logic                  w_start;
    logic                  w_route;
    logic                  w_load;
    logic                  w_err;
    logic                  w_drop;

    assign w_sel      = in_data[SEL_LSB +: SEL_BITS];
    assign w_in_range = 32'(w_sel) < N_OUT;

`ifdef FORK_BROADCAST_EN
    assign w_sel_bc = &w_sel;
`else
    assign w_sel_bc = 1'b0;
`endif

    // A broadcast flit leaves only when every lane is ready at once.
    assign w_out_acc = r_valid &&
                       (r_bcast ? &out_ready : out_ready[r_dest]);

    // DROP never loads the register, so it never backpressures.
    assign in_ready = (r_state == S_DROP) || !r_valid || w_out_acc;
    assign w_in_acc = in_valid && in_ready;

    assign w_start = (r_state == S_IDLE) && w_in_acc && in_sop;
    assign w_route = w_start && (w_in_range || w_sel_bc);
    assign w_load  = w_route || ((r_state == S_FWD) && w_in_acc);

    assign w_err  = w_in_acc &&
                    (((r_state == S_IDLE) && !in_sop) ||
                     ((r_state != S_IDLE) && in_sop));
    assign w_drop = (w_start && !w_route && in_eop) ||
                    ((r_state == S_DROP) && w_in_acc && in_eop);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_bcast <= 1'b0;
            r_data  <= '0;
            r_empty <= '0;
            r_dest  <= '0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= in_data;
                r_sop   <= in_sop;
                r_eop   <= in_eop;
                r_empty <= in_empty;
            end else if (w_out_acc) begin
                r_valid <= 1'b0;
            end
            // Safe to retarget: a new SOP is only accepted once the
            // register is empty or draining this cycle.
            if (w_route) begin
                r_dest  <= w_sel[DW-1:0];
                r_bcast <= w_sel_bc;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start && !in_eop) begin
                        r_state <= w_route ? S_FWD : S_DROP;
                    end
                end
                S_FWD, S_DROP: begin
                    if (w_in_acc && in_eop) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < N_OUT; i++) begin
                r_pkt[i] <= '0;
            end
            r_drop <= '0;
            r_err  <= '0;
        end else if (stats_clr) begin
            for (int i = 0; i < N_OUT; i++) begin
                r_pkt[i] <= '0;
            end
            r_drop <= '0;
            r_err  <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (w_out_acc && r_eop && out_valid[i]) begin
                    r_pkt[i] <= r_pkt[i] + 32'd1;
                end
            end
            if (w_drop) begin
                r_drop <= r_drop + 32'd1;
            end
            if (w_err) begin
                r_err <= r_err + 32'd1;
            end
        end
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_lane
        assign out_valid[i] = r_valid && (r_bcast || r_dest == DW'(i));
        assign out_sop[i]   = out_valid[i] && r_sop;
        assign out_eop[i]   = out_valid[i] && r_eop;
        assign out_data[i*DATA_BITS +: DATA_BITS] = r_data;
        assign out_empty[i*EMPTY_BITS +: EMPTY_BITS] =
            out_valid[i] ? r_empty : '0;
        assign stats_pkt[32*i +: 32] = r_pkt[i];
    end

    assign stats_drop = r_drop;
    assign stats_err  = r_err;

endmodule

// File: tb/tb_fork_n_service.sv
// tb_fork_n_service: directed vector table plus hand-written sequences
// for backpressure, mid-packet reset, counter clear and broadcast.
module tb_fork_n_service;

    localparam int DB = 512;
    localparam int EB = 6;
    localparam int NO = 4;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic [DB-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_sop;
    logic              in_eop;
    logic [EB-1:0]     in_empty;
    logic [NO*DB-1:0]  out_data;
    logic [NO-1:0]     out_valid;
    logic [NO-1:0]     out_ready;
    logic [NO-1:0]     out_sop;
    logic [NO-1:0]     out_eop;
    logic [NO*EB-1:0]  out_empty;
    logic              stats_clr;
    logic [NO*32-1:0]  stats_pkt;
    logic [31:0]       stats_drop;
    logic [31:0]       stats_err;

    int n_vec = 0;
    int n_err = 0;

    fork_n_service #(
        .DATA_BITS (DB),
        .EMPTY_BITS(EB),
        .N_OUT     (NO),
        .SEL_LSB   (0),
        .SEL_BITS  (4)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_empty  (in_empty),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_empty (out_empty),
        .stats_clr (stats_clr),
        .stats_pkt (stats_pkt),
        .stats_drop(stats_drop),
        .stats_err (stats_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        vld;
        logic        sop;
        logic        eop;
        logic [31:0] dat;
        logic [5:0]  emp;
        logic        e_rdy;
        logic [3:0]  e_ov;
        logic [3:0]  e_sop;
        logic [3:0]  e_eop;
        logic [31:0] e_dat;
        logic [23:0] e_emp;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic vld, input logic sop, input logic eop,
                       input logic [31:0] dat, input logic [5:0] emp,
                       input logic e_rdy, input logic [3:0] e_ov,
                       input logic [3:0] e_sop, input logic [3:0] e_eop,
                       input logic [31:0] e_dat, input logic [23:0] e_emp);
        vec_t v;
        v.vld = vld; v.sop = sop; v.eop = eop; v.dat = dat; v.emp = emp;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_sop = e_sop;
        v.e_eop = e_eop; v.e_dat = e_dat; v.e_emp = e_emp;
        tv.push_back(v);
    endtask

    task automatic drive(input logic vld, input logic sop, input logic eop,
                         input logic [31:0] dat, input logic [5:0] emp);
        in_valid = vld;
        in_sop   = sop;
        in_eop   = eop;
        in_data  = {{(DB-32){1'b0}}, dat};
        in_empty = emp;
    endtask

    initial begin
        int rx;
        int k;
        logic [31:0] prev_dat;
        logic        prev_stall;

        drive(1'b0, 1'b0, 1'b0, 32'h0, 6'h0);
        out_ready = 4'hF;
        stats_clr = 1'b0;

        // route sel=2, 3 flits, empty=5 on EOP
        add(1,1,0,32'hA002,0, 1,4'h0,4'h0,4'h0,32'h0,    24'h0);
        add(1,0,0,32'hA011,0, 1,4'h4,4'h4,4'h0,32'hA002, 24'h0);
        add(1,0,1,32'hA021,5, 1,4'h4,4'h0,4'h0,32'hA011, 24'h0);
        add(0,0,0,32'h0,   0, 1,4'h4,4'h0,4'h4,32'hA021, 24'h005000);
        add(0,0,0,32'h0,   0, 1,4'h0,4'h0,4'h0,32'hA021, 24'h0);
        // sel=6 out of range: 5 flits dropped
        add(1,1,0,32'hB006,0, 1,4'h0,4'h0,4'h0,32'hA021, 24'h0);
        add(1,0,0,32'hB010,0, 1,4'h0,4'h0,4'h0,32'hA021, 24'h0);
        add(1,0,0,32'hB020,0, 1,4'h0,4'h0,4'h0,32'hA021, 24'h0);
        add(1,0,0,32'hB030,0, 1,4'h0,4'h0,4'h0,32'hA021, 24'h0);
        add(1,0,1,32'hB040,0, 1,4'h0,4'h0,4'h0,32'hA021, 24'h0);
        // following sel=0 single-flit packet forwarded
        add(1,1,1,32'hC000,3, 1,4'h0,4'h0,4'h0,32'hA021, 24'h0);
        add(0,0,0,32'h0,   0, 1,4'h1,4'h1,4'h1,32'hC000, 24'h000003);
        // stray flit in IDLE, then SOP mid-packet on lane 1
        add(1,0,0,32'hD001,0, 1,4'h0,4'h0,4'h0,32'hC000, 24'h0);
        add(1,1,0,32'hD011,0, 1,4'h0,4'h0,4'h0,32'hC000, 24'h0);
        add(1,1,0,32'hD023,0, 1,4'h2,4'h2,4'h0,32'hD011, 24'h0);
        add(1,0,1,32'hD030,0, 1,4'h2,4'h2,4'h0,32'hD023, 24'h0);
        add(0,0,0,32'h0,   0, 1,4'h2,4'h0,4'h2,32'hD030, 24'h0);
        add(0,0,0,32'h0,   0, 1,4'h0,4'h0,4'h0,32'hD030, 24'h0);

        repeat (2) @(negedge Clk);
        #1;
        chk("rst_ov", 64'(out_valid), 64'h0);
        chk("rst_sop_eop", 64'({out_sop, out_eop}), 64'h0);
        chk("rst_data", 64'(out_data[63:0]), 64'h0);
        chk("rst_cnt", 64'(stats_pkt[63:0] | stats_pkt[127:64]), 64'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        chk("rst_rdy", 64'(in_ready), 64'h1);

        foreach (tv[i]) begin
            @(negedge Clk);
            drive(tv[i].vld, tv[i].sop, tv[i].eop, tv[i].dat, tv[i].emp);
            #1;
            chk($sformatf("v%0d_rdy", i), 64'(in_ready), 64'(tv[i].e_rdy));
            chk($sformatf("v%0d_ov", i), 64'(out_valid), 64'(tv[i].e_ov));
            chk($sformatf("v%0d_sop", i), 64'(out_sop), 64'(tv[i].e_sop));
            chk($sformatf("v%0d_eop", i), 64'(out_eop), 64'(tv[i].e_eop));
            chk($sformatf("v%0d_dat", i), 64'(out_data[31:0]),
                64'(tv[i].e_dat));
            chk($sformatf("v%0d_emp", i), 64'(out_empty), 64'(tv[i].e_emp));
        end
        chk("pkt0", 64'(stats_pkt[31:0]), 64'd1);
        chk("pkt1", 64'(stats_pkt[63:32]), 64'd1);
        chk("pkt2", 64'(stats_pkt[95:64]), 64'd1);
        chk("pkt3", 64'(stats_pkt[127:96]), 64'd0);
        chk("drop", 64'(stats_drop), 64'd1);
        chk("err", 64'(stats_err), 64'd2);

        // backpressure: 8 flits to lane 1, lane 1 stalled 4 cycles
        rx = 0;
        k = 0;
        prev_stall = 1'b0;
        prev_dat = '0;
        for (int c = 0; c < 60 && rx < 8; c++) begin
            @(negedge Clk);
            out_ready = (c >= 4 && c < 8) ? 4'hD : 4'hF;
            drive(k < 8, k == 0, k == 7, 32'hE001 | 32'(k << 4), 6'h0);
            #1;
            if (prev_stall) begin
                chk("bp_hold", 64'(out_data[31:0]), 64'(prev_dat));
            end
            prev_stall = out_valid[1] && !out_ready[1];
            prev_dat = out_data[31:0];
            if (prev_stall) begin
                chk("bp_rdy", 64'(in_ready), 64'h0);
            end
            if (out_valid[1] && out_ready[1]) begin
                chk($sformatf("bp_flit%0d", rx), 64'(out_data[31:0]),
                    64'(32'hE001 | 32'(rx << 4)));
                rx++;
            end
            if (in_valid && in_ready) k++;
        end
        chk("bp_count", 64'(rx), 64'd8);
        @(negedge Clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 6'h0);
        out_ready = 4'hF;
        #1;
        chk("bp_pkt1", 64'(stats_pkt[63:32]), 64'd2);
        chk("bp_ov", 64'(out_valid), 64'h0);

        // reset during flit 2 of a 4-flit packet
        @(negedge Clk);
        drive(1'b1, 1'b1, 1'b0, 32'hF013, 6'h0);
        @(negedge Clk);
        drive(1'b1, 1'b0, 1'b0, 32'hF020, 6'h0);
        @(negedge Clk);
        drive(1'b1, 1'b0, 1'b0, 32'hF030, 6'h0);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("mrst_ov", 64'(out_valid), 64'h0);
        chk("mrst_sop_eop", 64'({out_sop, out_eop}), 64'h0);
        chk("mrst_data", 64'(out_data[63:0]), 64'h0);
        chk("mrst_emp", 64'(out_empty), 64'h0);
        chk("mrst_pkt", 64'(stats_pkt[63:0] | stats_pkt[127:64]), 64'h0);
        chk("mrst_de", 64'({stats_drop, stats_err}), 64'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 6'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'hF103, 6'h7);
        #1;
        chk("mrst_rdy", 64'(in_ready), 64'h1);
        @(negedge Clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 6'h0);
        stats_clr = 1'b1;
        #1;
        chk("one_ov", 64'(out_valid), 64'h8);
        chk("one_se", 64'({out_sop, out_eop}), 64'h88);
        chk("one_dat", 64'(out_data[3*DB +: 32]), 64'hF103);
        chk("one_emp", 64'(out_empty), 64'h1C0000);
        @(negedge Clk);
        stats_clr = 1'b0;
        #1;
        chk("clr_ov", 64'(out_valid), 64'h0);
        chk("clr_pkt3", 64'(stats_pkt[127:96]), 64'd0);

`ifdef FORK_BROADCAST_EN
        // broadcast sel=15, lane 3 not ready for 2 cycles
        @(negedge Clk);
        out_ready = 4'h7;
        drive(1'b1, 1'b1, 1'b0, 32'h600F, 6'h0);
        #1;
        chk("bc_rdy0", 64'(in_ready), 64'h1);
        for (int s = 0; s < 2; s++) begin
            @(negedge Clk);
            drive(1'b1, 1'b0, 1'b1, 32'h601F, 6'h2);
            #1;
            chk("bc_stall_ov", 64'(out_valid), 64'hF);
            chk("bc_stall_rdy", 64'(in_ready), 64'h0);
            chk("bc_stall_dat", 64'(out_data[31:0]), 64'h600F);
        end
        @(negedge Clk);
        out_ready = 4'hF;
        #1;
        chk("bc_go_rdy", 64'(in_ready), 64'h1);
        chk("bc_go_sop", 64'(out_sop), 64'hF);
        @(negedge Clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 6'h0);
        #1;
        chk("bc_eop", 64'(out_eop), 64'hF);
        chk("bc_dat", 64'(out_data[2*DB +: 32]), 64'h601F);
        @(negedge Clk);
        #1;
        chk("bc_ov_end", 64'(out_valid), 64'h0);
        for (int l = 0; l < NO; l++) begin
            chk($sformatf("bc_pkt%0d", l), 64'(stats_pkt[32*l +: 32]), 64'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
